seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands offered.
REQ-005 SHALL have port in_ready  output  1  divider can accept operands.
REQ-006 SHALL have port dividend  input  WIDTH  numerator.
REQ-007 SHALL have port divisor  input  WIDTH  denominator.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  WIDTH  result quotient.
REQ-011 SHALL have port remainder  output  WIDTH  result remainder.
REQ-012 SHALL have port div_by_zero  output  1  result came from divisor == 0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL accept operands on the edge where in_valid && in_ready; accepted operands are latched internally, later input changes have no effect.
REQ-015 SHALL, on accept with divisor != 0, enter RUN with iteration counter = WIDTH-1.
REQ-016 SHALL, in RUN, per cycle: shift {partial_rem, quotient_shift} left 1, trial-subtract divisor from partial remainder, keep difference and set quotient LSB = 1 if non-negative, else restore and set LSB = 0 (radix-2 restoring).
REQ-017 SHALL leave RUN for DONE after exactly WIDTH iterations; out_valid first high WIDTH cycles after the accept edge.
REQ-018 SHALL, on accept with divisor == 0, go directly to DONE (out_valid high 1 cycle after accept) with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-019 SHALL hold quotient, remainder, div_by_zero stable in DONE while out_ready = 0.
REQ-020 SHALL return to IDLE on the edge where out_valid && out_ready; no accept in that same cycle (in_ready rises the following cycle).
REQ-021 SHALL keep quotient/remainder/div_by_zero at their last values after handshake until the next result is loaded.
REQ-022 SHALL guarantee unsigned results satisfy dividend = quotient*divisor + remainder, remainder < divisor.

Reset
REQ-023 SHALL, on rst assertion at any time (including mid-RUN or in DONE), go to IDLE immediately, discard in-flight operation, drive quotient = 0, remainder = 0, div_by_zero = 0, out_valid = 0, in_ready = 1 from deassertion.

Configuration
REQ-024 SHALL support macro SEQ_DIVIDER_SIGNED_EN; undefined: operands and results unsigned.
REQ-025 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, treat operands as two's complement: divide magnitudes, quotient truncates toward zero, remainder takes sign of dividend, sign correction applied on RUN->DONE transition with no added latency.
REQ-026 SHALL, signed, return quotient = most-negative value and remainder = 0 for most-negative / -1 (wrap); divide-by-zero behaviour per REQ-018 unchanged.

Structure
REQ-027 SHALL place FSM state enum (IDLE/RUN/DONE) and default WIDTH constant in shared package seq_divider_pkg.
REQ-028 SHALL implement the trial subtraction in sub-module div_step (WIDTH+1-bit subtract, outputs difference and non-negative flag), built on the team's existing ripple carry-propagate adder with inverted divisor and carry-in 1.

Verification (WIDTH = 8)
REQ-029 SHALL cover unsigned 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, out_valid exactly 8 cycles after accept.
REQ-030 SHALL cover 5 / 0 -> quotient 0xFF, remainder 5, div_by_zero 1, out_valid 1 cycle after accept.
REQ-031 SHALL cover 255 / 1 with out_ready held low 3 cycles in DONE -> quotient 255, remainder 0 stable all 3 cycles, in_ready 0 throughout, in_ready 1 the cycle after handshake.
REQ-032 SHALL cover rst asserted during iteration 4 of 200 / 3 -> out_valid 0, outputs 0, in_ready 1 after release; following 9 / 4 -> quotient 2, remainder 1.
REQ-033 SHALL cover (SEQ_DIVIDER_SIGNED_EN) -7 / 2 -> quotient 0xFD, remainder 0xFF; -128 / -1 -> quotient 0x80, remainder 0; latency still 8 cycles.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM state encoding and default operand width for seq_divider.
package seq_divider_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division trial subtraction, built on the ripple carry-propagate adder rca.
module rca #(parameter int N = 9) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);
   logic [N:0] c;
   assign c[0] = ci;
   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bit
         assign s[i]   = a[i] ^ b[i] ^ c[i];
         assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   endgenerate
   assign co = c[N];
endmodule

module div_step #(parameter int WIDTH = 8) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] diff,
   output logic             nonneg
);
   logic [WIDTH:0] sum;
   logic           co;
   rca #(.N(WIDTH+1)) u_rca (
      .a  (partial),
      .b  (~{1'b0, divisor}),
      .ci (1'b1),
      .s  (sum),
      .co (co)
   );
   // no borrow means partial >= divisor; the difference then always fits WIDTH bits
   assign nonneg = co & ~sum[WIDTH];
   assign diff   = sum[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring sequential divider with valid/ready handshakes.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient, remainder follows dividend).
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   state_t           state, state_nx;
   logic [WIDTH-1:0] rem, qsh, dvs, ma, mb, q_nx, r_nx, q_fix, r_fix;
   logic [WIDTH:0]   partial;
   logic [CW-1:0]    cnt;
   logic             a_neg, b_neg, q_neg, r_neg, nonneg, accept;
   logic [WIDTH-1:0] diff;
`ifdef SEQ_DIVIDER_SIGNED_EN
   assign a_neg = dividend[WIDTH-1];
   assign b_neg = divisor[WIDTH-1];
`else
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
`endif
   assign ma      = a_neg ? -dividend : dividend;
   assign mb      = b_neg ? -divisor : divisor;
   assign accept  = in_valid && in_ready;
   assign partial = {rem, qsh[WIDTH-1]};
   div_step #(.WIDTH(WIDTH)) u_step (
      .partial (partial),
      .divisor (dvs),
      .diff    (diff),
      .nonneg  (nonneg)
   );
   assign r_nx  = nonneg ? diff : partial[WIDTH-1:0];
   assign q_nx  = {qsh[WIDTH-2:0], nonneg};
   // sign fix-up folds into the final iteration edge; most-negative / -1 wraps naturally
   assign q_fix = q_neg ? -q_nx : q_nx;
   assign r_fix = r_neg ? -r_nx : r_nx;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state == IDLE ? (accept ? (divisor == '0 ? DONE : RUN) : IDLE)
               : state == RUN  ? (cnt == '0 ? DONE : RUN)
               : (out_ready ? IDLE : DONE);
   end
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem         <= '0;
         qsh         <= '0;
         dvs         <= '0;
         cnt         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         rem   <= '0;
         qsh   <= ma;
         dvs   <= mb;
         cnt   <= CW'(WIDTH-1);
         q_neg <= a_neg ^ b_neg;
         r_neg <= a_neg;
         if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         rem <= r_nx;
         qsh <= q_nx;
         cnt <= cnt - CW'(1);
         if (cnt == '0) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
         end
      end
   end
endmodule
